score_display: RTL and testbench
================================

Name: score_display

Overview:
- Reader side of the score path. Takes the 8-bit binary score from the score counter and converts it to three BCD digits with an iterative double-dabble FSM.
- Drives the board's active-low 7-segment displays, with leading zeros blanked.
- Sits between the score counter and the top-level HEX pins. Runs on the game clock.

Parameters:
- SCORE_W, 8, width of the binary score input. The design is verified only at 8; 3 BCD digits cover a maximum of 255.
- CONV_CYCLES, 8, number of shift iterations. Must equal SCORE_W.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- score_in  in  8  binary score from the score counter
- bcd_hundreds  out  4  latched BCD hundreds digit
- bcd_tens  out  4  latched BCD tens digit
- bcd_ones  out  4  latched BCD ones digit
- bcd_valid  out  1  one-cycle pulse when the digit outputs update
- busy  out  1  high while a conversion is in progress
- HEX0  out  7  ones digit, active-low segments {g,f,e,d,c,b,a}
- HEX1  out  7  tens digit, active-low
- HEX2  out  7  hundreds digit, active-low
- HEX4  out  7  high-score ones digit (see Optional Feature)
- HEX5  out  7  high-score tens digit
- HEX6  out  7  high-score hundreds digit

Behaviour:
- Reset (synchronous, active-high, on Clk) sets:
  - state = IDLE, score_last = 0, shift register = 0, iteration counter = 0
  - BCD outputs = 0, bcd_valid = 0, busy = 0
  - HEX0 = 7'b1000000 ("0"); HEX1, HEX2 = 7'h7F (blank)
- Reset takes priority over everything and aborts a conversion mid-flight. No partial result is ever latched.
- State IDLE:
  - Start condition: score_in != score_last at an edge.
  - On that edge: load a 20-bit shift register with {12'b0, score_in}, set score_last <= score_in, clear the counter, go to CONV.
  - busy is registered and goes high on that same edge.
- State CONV, one iteration per cycle:
  - Add 3 to each of the three BCD nibbles (bits [19:16], [15:12], [11:8]) that are >= 5.
  - Then shift the whole 20-bit register left by 1.
  - After the 8th iteration (counter == 7), go to DONE.
- State DONE, one cycle:
  - Copy bits [19:8] to bcd_hundreds/tens/ones.
  - Update HEX0..HEX2.
  - bcd_valid = 1 for this cycle only; busy drops at the end of the cycle; go to IDLE.
- Latency:
  - Capture edge E; CONV at edges E+1..E+8; outputs visible after edge E+9.
  - Minimum spacing between two captures is 10 cycles.
- Input changes while busy are ignored, not queued. On return to IDLE, any mismatch with score_last starts a new conversion, so the final settled score is always displayed.
- A score that changes and then returns to score_last while busy causes no new conversion.
- Digit blanking is combinational from the latched BCD, then registered into HEX*:
  - Hundreds is blank if 0.
  - Tens is blank if hundreds == 0 and tens == 0.
  - Ones is always shown.
- Segment encoding (active-low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A nibble > 9 is impossible; encode it as blank.
- Wrap: score 255 -> 0 (counter overflow) is just a normal change; the display shows "  0".

Optional Feature:
- Macro: SCORE_DISPLAY_HIGH_SCORE_EN.
- When defined:
  - Adds an 8-bit hi_bin register and a 12-bit hi_bcd register, both reset to 0.
  - In DONE, if score_last > hi_bin, load hi_bin <= score_last and hi_bcd <= the new BCD result, in the same cycle as the main update.
  - HEX4..HEX6 show hi_bcd using the same blanking rules. After reset they show "  0".
  - hi_bin is not cleared by the score dropping to 0; only Reset clears it.
- When undefined:
  - No high-score registers exist.
  - HEX4, HEX5, HEX6 are tied to 7'h7F.

Test Plan:
- Reset with score_in=0 -> HEX2=7F, HEX1=7F, HEX0=1000000; bcd=0/0/0; busy=0; no bcd_valid pulse for 20 cycles.
- score_in 0->137 at edge E -> busy high E..E+9; bcd_valid pulses only at E+9; then bcd=1/3/7, HEX2=1111001, HEX1=0110000, HEX0=1111000.
- score_in=5, then 255 -> first conversion gives HEX2=HEX1=7F, HEX0=0010010; second gives 2/5/5 with all digits lit. Then 255->0 gives "  0".
- score_in 10->11->12 within 3 cycles of a capture -> first conversion shows 10 (or 11, per the capture edge); a second conversion follows automatically; the final display is 12 and bcd_valid pulses exactly twice.
- Reset asserted at CONV iteration 4 of a 0->200 conversion -> next cycle state=IDLE and outputs are the reset values. With score_in held at 200, a conversion starts on the first edge after Reset deasserts and shows 200.
- With SCORE_DISPLAY_HIGH_SCORE_EN, sequence 42, 0, 17, 99 -> HEX6..4 show 42, stay 42, then 99. Without the macro, HEX4..6 remain 7F throughout.

Source files
------------

// File: rtl/score_display.sv
// Binary score to 3-digit BCD (iterative double-dabble) driving active-low 7-segment displays.
// Define SCORE_DISPLAY_HIGH_SCORE_EN to add a high-score register shown on HEX4..HEX6.
module score_display #(
  parameter int SCORE_W     = 8,
  parameter int CONV_CYCLES = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [SCORE_W-1:0] score_in,
  output logic [3:0]         bcd_hundreds,
  output logic [3:0]         bcd_tens,
  output logic [3:0]         bcd_ones,
  output logic               bcd_valid,
  output logic               busy,
  output logic [6:0]         HEX0,
  output logic [6:0]         HEX1,
  output logic [6:0]         HEX2,
  output logic [6:0]         HEX4,
  output logic [6:0]         HEX5,
  output logic [6:0]         HEX6
);

  localparam int          SR_W      = SCORE_W + 12;
  localparam int          CNT_W     = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [6:0]  SEG_BLANK = 7'h7F;
  localparam logic [20:0] HEX_RST   = {SEG_BLANK, SEG_BLANK, 7'b1000000};

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Returns {hundreds, tens, ones} segments with leading zeros blanked.
  function automatic logic [20:0] bcd_to_hex(input logic [11:0] bcd);
    logic [6:0] h, t, o;
    h = (bcd[11:8] == 4'd0) ? SEG_BLANK : seg7(bcd[11:8]);
    t = (bcd[11:8] == 4'd0 && bcd[7:4] == 4'd0) ? SEG_BLANK : seg7(bcd[7:4]);
    o = seg7(bcd[3:0]);
    return {h, t, o};
  endfunction

  function automatic logic [SR_W-1:0] dd_step(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] t;
    t = sr;
    for (int i = 0; i < 3; i++) begin
      if (t[SR_W-1-4*i -: 4] >= 4'd5)
        t[SR_W-1-4*i -: 4] = t[SR_W-1-4*i -: 4] + 4'd3;
    end
    return {t[SR_W-2:0], 1'b0};
  endfunction

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] score_last_q, score_last_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [11:0]        bcd_q, bcd_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic [20:0]        hex_q, hex_d;
  logic [11:0]        result;

  assign result = sr_q[SR_W-1 -: 12];

  always_comb begin
    state_d      = state_q;
    score_last_d = score_last_q;
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    bcd_d        = bcd_q;
    valid_d      = 1'b0;
    busy_d       = busy_q;
    hex_d        = hex_q;
    case (state_q)
      IDLE: begin
        if (score_in != score_last_q) begin
          sr_d         = {12'b0, score_in};
          score_last_d = score_in;
          cnt_d        = '0;
          busy_d       = 1'b1;
          state_d      = CONV;
        end
      end
      CONV: begin
        sr_d  = dd_step(sr_q);
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(CONV_CYCLES - 1))
          state_d = DONE;
      end
      DONE: begin
        // Segments come from the finished shift register so HEX and BCD update together.
        bcd_d   = result;
        hex_d   = bcd_to_hex(result);
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      score_last_q <= '0;
      sr_q         <= '0;
      cnt_q        <= '0;
      bcd_q        <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      hex_q        <= HEX_RST;
    end else begin
      state_q      <= state_d;
      score_last_q <= score_last_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      bcd_q        <= bcd_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      hex_q        <= hex_d;
    end
  end

  assign bcd_hundreds = bcd_q[11:8];
  assign bcd_tens     = bcd_q[7:4];
  assign bcd_ones     = bcd_q[3:0];
  assign bcd_valid    = valid_q;
  assign busy         = busy_q;
  assign {HEX2, HEX1, HEX0} = hex_q;

`ifdef SCORE_DISPLAY_HIGH_SCORE_EN
  logic [SCORE_W-1:0] hi_bin_q, hi_bin_d;
  logic [11:0]        hi_bcd_q, hi_bcd_d;
  logic [20:0]        hi_hex_q, hi_hex_d;

  always_comb begin
    hi_bin_d = hi_bin_q;
    hi_bcd_d = hi_bcd_q;
    hi_hex_d = hi_hex_q;
    if (state_q == DONE && score_last_q > hi_bin_q) begin
      hi_bin_d = score_last_q;
      hi_bcd_d = result;
      hi_hex_d = bcd_to_hex(result);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hi_bin_q <= '0;
      hi_bcd_q <= '0;
      hi_hex_q <= HEX_RST;
    end else begin
      hi_bin_q <= hi_bin_d;
      hi_bcd_q <= hi_bcd_d;
      hi_hex_q <= hi_hex_d;
    end
  end

  assign {HEX6, HEX5, HEX4} = hi_hex_q;
`else
  assign HEX4 = SEG_BLANK;
  assign HEX5 = SEG_BLANK;
  assign HEX6 = SEG_BLANK;
`endif

endmodule

// File: tb/tb_score_display.sv
// Directed, table-driven bench for score_display: conversions, blanking, latency,
// input changes while busy, and reset in the middle of a conversion.
module tb_score_display;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S7 = 7'b1111000, S8 = 7'b0000000, S6 = 7'b0000010,
                         S9 = 7'b0010000, BL = 7'h7F;

  typedef struct {
    logic [7:0]  score;
    logic [11:0] bcd;
    logic [20:0] hex;
    logic [20:0] hi;
  } vec_t;

  logic       Clk, Reset;
  logic [7:0] score_in;
  logic [3:0] bcd_hundreds, bcd_tens, bcd_ones;
  logic       bcd_valid, busy;
  logic [6:0] HEX0, HEX1, HEX2, HEX4, HEX5, HEX6;

  int pass_cnt = 0;
  int total_cnt = 0;

  score_display dut (
    .Clk(Clk), .Reset(Reset), .score_in(score_in),
    .bcd_hundreds(bcd_hundreds), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
    .bcd_valid(bcd_valid), .busy(busy),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2),
    .HEX4(HEX4), .HEX5(HEX5), .HEX6(HEX6)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [20:0] exp_hi(input logic [20:0] h);
`ifdef SCORE_DISPLAY_HIGH_SCORE_EN
    return h;
`else
    return {BL, BL, BL};
`endif
  endfunction

  // Waits for bcd_valid, counting negedges since the input was driven; bounded.
  task automatic wait_valid(output int n, output logic busy_first);
    n = 0;
    busy_first = 1'b0;
    do begin
      @(negedge Clk);
      n++;
      if (n == 1) busy_first = busy;
    end while (!bcd_valid && n < 20);
  endtask

  task automatic count_pulses(input int cycles, output int pulses, output logic [11:0] first);
    pulses = 0;
    first = '0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge Clk);
      if (bcd_valid) begin
        if (pulses == 0) first = {bcd_hundreds, bcd_tens, bcd_ones};
        pulses++;
      end
    end
  endtask

  vec_t vecs[11];

  initial begin
    int          n, pulses;
    logic        b1;
    logic [11:0] first;
    bit          seen;

    vecs[0]  = '{8'd42,  12'h042, {BL, S4, S2}, {BL, S4, S2}};
    vecs[1]  = '{8'd0,   12'h000, {BL, BL, S0}, {BL, S4, S2}};
    vecs[2]  = '{8'd17,  12'h017, {BL, S1, S7}, {BL, S4, S2}};
    vecs[3]  = '{8'd99,  12'h099, {BL, S9, S9}, {BL, S9, S9}};
    vecs[4]  = '{8'd137, 12'h137, {S1, S3, S7}, {S1, S3, S7}};
    vecs[5]  = '{8'd5,   12'h005, {BL, BL, S5}, {S1, S3, S7}};
    vecs[6]  = '{8'd255, 12'h255, {S2, S5, S5}, {S2, S5, S5}};
    vecs[7]  = '{8'd0,   12'h000, {BL, BL, S0}, {S2, S5, S5}};
    vecs[8]  = '{8'd100, 12'h100, {S1, S0, S0}, {S2, S5, S5}};
    vecs[9]  = '{8'd8,   12'h008, {BL, BL, S8}, {S2, S5, S5}};
    vecs[10] = '{8'd60,  12'h060, {BL, S6, S0}, {S2, S5, S5}};

    Reset = 1'b1;
    score_in = 8'd0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;

    check("reset_bcd", {bcd_hundreds, bcd_tens, bcd_ones}, 12'h000);
    check("reset_hex", {HEX2, HEX1, HEX0}, {BL, BL, S0});
    check("reset_hi_hex", {HEX6, HEX5, HEX4}, exp_hi({BL, BL, S0}));
    check("reset_busy", busy, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (bcd_valid || busy) seen = 1'b1;
    end
    check("idle_no_activity", seen, 1'b0);

    for (int i = 0; i < 11; i++) begin
      @(negedge Clk);
      score_in = vecs[i].score;
      wait_valid(n, b1);
      check($sformatf("v%0d_busy_start", i), b1, 1'b1);
      check($sformatf("v%0d_latency", i), n, 10);
      check($sformatf("v%0d_bcd", i), {bcd_hundreds, bcd_tens, bcd_ones}, vecs[i].bcd);
      check($sformatf("v%0d_hex", i), {HEX2, HEX1, HEX0}, vecs[i].hex);
      check($sformatf("v%0d_hi_hex", i), {HEX6, HEX5, HEX4}, exp_hi(vecs[i].hi));
      check($sformatf("v%0d_busy_end", i), busy, 1'b0);
      @(negedge Clk);
      check($sformatf("v%0d_valid_one_cycle", i), bcd_valid, 1'b0);
    end

    // Changes while busy: 10 captured, 12 picked up after return to IDLE.
    @(negedge Clk); score_in = 8'd10;
    @(negedge Clk); score_in = 8'd11;
    @(negedge Clk); score_in = 8'd12;
    count_pulses(40, pulses, first);
    check("chg_pulses", pulses, 2);
    check("chg_first_bcd", first, 12'h010);
    check("chg_final_bcd", {bcd_hundreds, bcd_tens, bcd_ones}, 12'h012);
    check("chg_final_hex", {HEX2, HEX1, HEX0}, {BL, S1, S2});

    // Change that returns to the captured value while busy: single conversion.
    @(negedge Clk); score_in = 8'd30;
    @(negedge Clk); score_in = 8'd31;
    @(negedge Clk); score_in = 8'd30;
    count_pulses(30, pulses, first);
    check("ret_pulses", pulses, 1);
    check("ret_bcd", {bcd_hundreds, bcd_tens, bcd_ones}, 12'h030);
    check("ret_hex", {HEX2, HEX1, HEX0}, {BL, S3, S0});

    // Reset at the 4th conversion iteration of 30->200.
    @(negedge Clk); score_in = 8'd200;
    repeat (4) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_valid", bcd_valid, 1'b0);
    check("mid_rst_bcd", {bcd_hundreds, bcd_tens, bcd_ones}, 12'h000);
    check("mid_rst_hex", {HEX2, HEX1, HEX0}, {BL, BL, S0});
    check("mid_rst_hi_hex", {HEX6, HEX5, HEX4}, exp_hi({BL, BL, S0}));
    Reset = 1'b0;
    wait_valid(n, b1);
    check("post_rst_busy_start", b1, 1'b1);
    check("post_rst_latency", n, 10);
    check("post_rst_bcd", {bcd_hundreds, bcd_tens, bcd_ones}, 12'h200);
    check("post_rst_hex", {HEX2, HEX1, HEX0}, {S2, S0, S0});
    check("post_rst_hi_hex", {HEX6, HEX5, HEX4}, exp_hi({S2, S0, S0}));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
